operand_fetch_stage: RTL

//  Read-side client of the 8x8 CPU register file. Takes decoded instructions from decode,

---
 rtl/cpu8_pkg.sv | 11 +
 rtl/reg_scoreboard.sv | 48 ++++
 rtl/operand_fetch_stage.sv | 110 +++++++++++
 3 files changed

// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit CPU: datapath width, register-file geometry
// and the opcode type. Decode, execute, the register file and operand fetch all
// import it.
package cpu8_pkg;
  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;
  localparam int OP_W       = 4;

  typedef logic [OP_W-1:0] opcode_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// Ports:
//   clk, rst            clock / synchronous active-high reset (clears all busy)
//   set_en, set_idx     mark a register as having a write in flight
//   clr_en, clr_idx     writeback retires the pending write to clr_idx
//   rs1_idx, rs2_idx,   lookup indices; *_pending is busy with the same-cycle
//   rd_idx              writeback bypassed (a register being written now is
//                       no longer pending from the reader's point of view)
//   busy                current busy vector (debug / observation)
module reg_scoreboard #(
  parameter int ADDR_W   = cpu8_pkg::REG_ADDR_W,
  parameter int NUM_REGS = cpu8_pkg::NUM_REGS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  logic [ADDR_W-1:0]   set_idx,
  input  logic                clr_en,
  input  logic [ADDR_W-1:0]   clr_idx,
  input  logic [ADDR_W-1:0]   rs1_idx,
  input  logic [ADDR_W-1:0]   rs2_idx,
  input  logic [ADDR_W-1:0]   rd_idx,
  output logic                rs1_pending,
  output logic                rs2_pending,
  output logic                rd_pending,
  output logic [NUM_REGS-1:0] busy
);
  import cpu8_pkg::*;

  logic [NUM_REGS-1:0] busy_nxt;

  // Clear first, then set: when the same register retires and is re-claimed in
  // one cycle, the new pending write must remain visible.
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_idx] = 1'b0;
    if (set_en) busy_nxt[set_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  assign rs1_pending = busy[rs1_idx] & ~(clr_en & (clr_idx == rs1_idx));
  assign rs2_pending = busy[rs2_idx] & ~(clr_en & (clr_idx == rs2_idx));
  assign rd_pending  = busy[rd_idx]  & ~(clr_en & (clr_idx == rd_idx));
endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: reads source registers from the RF, forwards same-cycle
// writeback data, stalls RAW/WAW hazards via reg_scoreboard and registers the
// instruction plus operands into a single slot feeding execute.
// Ports:
//   clk, rst                         clock / synchronous active-high reset
//   id_*                             instruction from decode (valid/ready)
//   rf_raddr1/2, rf_rdata1/2         combinational RF read port
//   wb_valid, wb_rd, wb_data         writeback (same cycle as RF write)
//   ex_*                             registered slot to execute (valid/ready)
//   dbg_busy                         scoreboard busy vector
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. Producers hold payload stable while valid & !ready; ready may depend
// combinationally on the consumer side (id_ready follows ex_ready and hazards).
module operand_fetch_stage #(
  parameter int DATA_W   = cpu8_pkg::DATA_W,
  parameter int ADDR_W   = cpu8_pkg::REG_ADDR_W,
  parameter int NUM_REGS = cpu8_pkg::NUM_REGS,
  parameter int OP_W     = cpu8_pkg::OP_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [OP_W-1:0]     id_opcode,
  input  logic [ADDR_W-1:0]   id_rd,
  input  logic [ADDR_W-1:0]   id_rs1,
  input  logic                id_use_rs1,
  input  logic [ADDR_W-1:0]   id_rs2,
  input  logic                id_use_rs2,
  input  logic                id_wr_rd,
  output logic [ADDR_W-1:0]   rf_raddr1,
  output logic [ADDR_W-1:0]   rf_raddr2,
  input  logic [DATA_W-1:0]   rf_rdata1,
  input  logic [DATA_W-1:0]   rf_rdata2,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_rd,
  input  logic [DATA_W-1:0]   wb_data,
  output logic                ex_valid,
  input  logic                ex_ready,
  output logic [OP_W-1:0]     ex_opcode,
  output logic [ADDR_W-1:0]   ex_rd,
  output logic                ex_wr_rd,
  output logic [DATA_W-1:0]   ex_op1,
  output logic [DATA_W-1:0]   ex_op2,
  output logic [NUM_REGS-1:0] dbg_busy
);
  import cpu8_pkg::*;

  logic slot_free;
  logic rs1_pending, rs2_pending, rd_pending;
  logic hazard_rs1, hazard_rs2, hazard_waw;
  logic issue;
  logic [DATA_W-1:0] op1_sel, op2_sel;

  assign rf_raddr1 = id_rs1;
  assign rf_raddr2 = id_rs2;

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .set_en      (issue & id_wr_rd),
    .set_idx     (id_rd),
    .clr_en      (wb_valid),
    .clr_idx     (wb_rd),
    .rs1_idx     (id_rs1),
    .rs2_idx     (id_rs2),
    .rd_idx      (id_rd),
    .rs1_pending (rs1_pending),
    .rs2_pending (rs2_pending),
    .rd_pending  (rd_pending),
    .busy        (dbg_busy)
  );

  assign slot_free  = ~ex_valid | ex_ready;
  assign hazard_rs1 = id_use_rs1 & rs1_pending;
  assign hazard_rs2 = id_use_rs2 & rs2_pending;
  assign hazard_waw = id_wr_rd   & rd_pending;
  assign id_ready   = slot_free & ~hazard_rs1 & ~hazard_rs2 & ~hazard_waw;
  assign issue      = id_valid & id_ready;

  // The RF write for wb lands on the same edge as our capture, so the RF read
  // port still shows the old value; take wb_data directly instead.
  assign op1_sel = (wb_valid && wb_rd == id_rs1) ? wb_data : rf_rdata1;
  assign op2_sel = (wb_valid && wb_rd == id_rs2) ? wb_data : rf_rdata2;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_opcode <= '0;
      ex_rd     <= '0;
      ex_wr_rd  <= 1'b0;
      ex_op1    <= '0;
      ex_op2    <= '0;
    end else if (issue) begin
      ex_valid  <= 1'b1;
      ex_opcode <= id_opcode;
      ex_rd     <= id_rd;
      ex_wr_rd  <= id_wr_rd;
      ex_op1    <= op1_sel;
      ex_op2    <= op2_sel;
    end else if (ex_ready) begin
      // Slot drained with nothing behind it; payload is left as-is.
      ex_valid <= 1'b0;
    end
  end
endmodule
